// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
//
// Decode stage of a five-stage RV32I-subset pipeline. Holds the IF/ID pipeline
// register, the 32x32 register file (with write-through bypass from
// writeback), the main/ALU decoder, the immediate generator and the load-use
// hazard detector.
//
// Ports
//   clk, reset          pipeline clock (rising edge), async active-high reset
//   InstrF, PCF,
//   PCPlus4F            fetched instruction and its PC values
//   FlushD              taken branch/jump resolved in EX; kill the decode slot
//   RegWriteW, RdW,
//   ResultW             writeback port into the register file
//   MemReadE, RdE       load currently in EX, for load-use detection
//   PCD, PCPlus4D       PC values of the instruction in decode
//   RD1D, RD2D          register operands (bypassed from writeback)
//   ImmExtD             sign-extended immediate
//   RdD, Rs1D, Rs2D     register indices
//   AluControlD ...     control bundle for the execute stage
//   StallF              freeze the PC register
//   FlushE              load a bubble into the ID/EX register
// -----------------------------------------------------------------------------
module decode_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] InstrF,
  input  logic [31:0] PCF,
  input  logic [31:0] PCPlus4F,
  input  logic        FlushD,
  input  logic        RegWriteW,
  input  logic [4:0]  RdW,
  input  logic [31:0] ResultW,
  input  logic        MemReadE,
  input  logic [4:0]  RdE,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic [31:0] RD1D,
  output logic [31:0] RD2D,
  output logic [31:0] ImmExtD,
  output logic [4:0]  RdD,
  output logic [4:0]  Rs1D,
  output logic [4:0]  Rs2D,
  output logic [2:0]  AluControlD,
  output logic [1:0]  ResultSrcD,
  output logic        RegWriteD,
  output logic        MemWriteD,
  output logic        MemReadD,
  output logic        JumpD,
  output logic        BranchD,
  output logic        ALUSrcD,
  output logic        StallF,
  output logic        FlushE
);

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_RTYPE  = 7'b0110011,
    OP_ITYPE  = 7'b0010011,
    OP_BRANCH = 7'b1100011,
    OP_JAL    = 7'b1101111
  } opcode_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_op_e;

  logic [31:0] instrD_q, instrD_d;
  logic [31:0] pcD_q, pcD_d;
  logic [31:0] pcPlus4D_q, pcPlus4D_d;
  logic [31:0] regs_q [0:31];

  logic        lwStall;
  opcode_e     opcode;
  logic [2:0]  funct3;
  logic        funct7b5;

  // R-type and I-type arithmetic share the funct3 mapping; only R-type may
  // turn add into sub via funct7[5], because on I-type that bit is immediate.
  function automatic alu_op_e funct3Alu(input logic [2:0] f3, input logic subSel);
    alu_op_e op;
    case (f3)
      3'b000:  op = subSel ? ALU_SUB : ALU_ADD;
      3'b010:  op = ALU_SLT;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  assign opcode   = opcode_e'(instrD_q[6:0]);
  assign funct3   = instrD_q[14:12];
  assign funct7b5 = instrD_q[30];

  assign Rs1D = instrD_q[19:15];
  assign Rs2D = instrD_q[24:20];
  assign RdD  = instrD_q[11:7];

  assign PCD      = pcD_q;
  assign PCPlus4D = pcPlus4D_q;

  // Load-use: the load in EX has no result until after MEM, so the consumer
  // in decode must wait one cycle. x0 never creates a dependency.
  assign lwStall = MemReadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
  assign StallF  = lwStall;
  assign FlushE  = lwStall | FlushD;

  // IF/ID next state: a flush wins over a stall, since the instruction being
  // held belongs to a mispredicted path and must be killed anyway.
  always_comb begin
    instrD_d   = instrD_q;
    pcD_d      = pcD_q;
    pcPlus4D_d = pcPlus4D_q;
    if (FlushD) begin
      instrD_d   = NOP_INSTR;
      pcD_d      = '0;
      pcPlus4D_d = '0;
    end else if (!lwStall) begin
      instrD_d   = InstrF;
      pcD_d      = PCF;
      pcPlus4D_d = PCPlus4F;
    end
  end

  // IF/ID register. Reset loads the NOP so the outputs show a harmless
  // addi x0,x0,0 decode immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instrD_q   <= NOP_INSTR;
      pcD_q      <= '0;
      pcPlus4D_q <= '0;
    end else begin
      instrD_q   <= instrD_d;
      pcD_q      <= pcD_d;
      pcPlus4D_q <= pcPlus4D_d;
    end
  end

  // Register file storage. Entry 0 is never written and never read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else if (RegWriteW && (RdW != 5'd0)) begin
      regs_q[RdW] <= ResultW;
    end
  end

  // Read port 1: x0 is hard zero; a same-cycle writeback to the index is
  // forwarded so decode never sees the stale value.
  always_comb begin
    RD1D = '0;
    if (Rs1D != 5'd0) begin
      if (RegWriteW && (RdW == Rs1D)) begin
        RD1D = ResultW;
      end else begin
        RD1D = regs_q[Rs1D];
      end
    end
  end

  // Read port 2, same rules as port 1.
  always_comb begin
    RD2D = '0;
    if (Rs2D != 5'd0) begin
      if (RegWriteW && (RdW == Rs2D)) begin
        RD2D = ResultW;
      end else begin
        RD2D = regs_q[Rs2D];
      end
    end
  end

  // Main decoder plus ALU control. Unknown opcodes decode to an all-zero
  // bundle so they behave as a bubble downstream.
  always_comb begin
    RegWriteD   = 1'b0;
    ALUSrcD     = 1'b0;
    MemWriteD   = 1'b0;
    MemReadD    = 1'b0;
    ResultSrcD  = 2'b00;
    BranchD     = 1'b0;
    JumpD       = 1'b0;
    AluControlD = ALU_ADD;
    case (opcode)
      OP_LOAD: begin
        RegWriteD  = 1'b1;
        ALUSrcD    = 1'b1;
        MemReadD   = 1'b1;
        ResultSrcD = 2'b01;
      end
      OP_STORE: begin
        ALUSrcD   = 1'b1;
        MemWriteD = 1'b1;
      end
      OP_RTYPE: begin
        RegWriteD   = 1'b1;
        AluControlD = funct3Alu(funct3, funct7b5);
      end
      OP_ITYPE: begin
        RegWriteD   = 1'b1;
        ALUSrcD     = 1'b1;
        AluControlD = funct3Alu(funct3, 1'b0);
      end
      OP_BRANCH: begin
        BranchD     = 1'b1;
        AluControlD = ALU_SUB;
      end
      OP_JAL: begin
        RegWriteD  = 1'b1;
        ResultSrcD = 2'b10;
        JumpD      = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Immediate generator. Formats without an immediate yield zero.
  always_comb begin
    ImmExtD = '0;
    case (opcode)
      OP_LOAD, OP_ITYPE:
        ImmExtD = {{20{instrD_q[31]}}, instrD_q[31:20]};
      OP_STORE:
        ImmExtD = {{20{instrD_q[31]}}, instrD_q[31:25], instrD_q[11:7]};
      OP_BRANCH:
        ImmExtD = {{20{instrD_q[31]}}, instrD_q[7], instrD_q[30:25],
                   instrD_q[11:8], 1'b0};
      OP_JAL:
        ImmExtD = {{12{instrD_q[31]}}, instrD_q[19:12], instrD_q[20],
                   instrD_q[30:21], 1'b0};
      default:
        ImmExtD = '0;
    endcase
  end

endmodule
